// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: MemtoReg select, load/store size codes,
// FSM states, the JALR opcode and the MEM/WB bundle layout.
package mem_stage_pkg;

    // Write-back source select carried in MemtoReg
    typedef enum logic [1:0] {
        MTR_ALU   = 2'b00,
        MTR_LOAD  = 2'b01,
        MTR_PC4   = 2'b10,
        MTR_PCIMM = 2'b11
    } mtr_e;

    // funct3 size/sign codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // Bus access FSM
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd_addr;
        mtr_e        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] mem_data;
        logic [31:0] pc4;
        logic [31:0] pc_imm;
        logic [31:0] inst;
        logic [31:0] pc;
    } memwb_t;

    // Halfwords need an even address, words a multiple of four; bytes never fault
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3 == F3_H || funct3 == F3_HU) mis = addr_lo[0];
        else if (funct3 == F3_W)               mis = (addr_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering between the 32-bit data bus and the core:
// store data/strobes are shifted into the addressed lanes, load data is
// shifted down and sign- or zero-extended.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] load_shifted;

    // Bring the addressed byte/halfword down to bit 0
    assign load_shifted = load_word >> {addr_lo, 3'b000};

    // Store path: place the low byte/half of rs2 in its lane, other lanes zero
    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {24'd0, store_data[7:0]} << {addr_lo, 3'b000};
            end
            F3_H: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {16'd0, store_data[15:0]} << {addr_lo[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Load path: extend the selected lane according to size and sign
    always_comb begin
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            F3_BU:   load_data = {24'd0, load_shifted[7:0]};
            F3_H:    load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3_HU:   load_data = {16'd0, load_shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/ack bus,
// stalls the front-end while an access is outstanding, aborts on timeout,
// resolves branch/jump redirects and registers the MEM/WB bundle.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_Mem,
    input  logic        rst_Mem,
    input  logic        valid_in_Mem,
    input  logic [31:0] PC4_in_Mem,
    input  logic [31:0] PC_imm_in_Mem,
    input  logic [31:0] ALU_in_Mem,
    input  logic [31:0] Rs2_in_Mem,
    input  logic [31:0] inst_in_Mem,
    input  logic [31:0] pc_in_Mem,
    input  logic [4:0]  Rd_addr_in_Mem,
    input  logic        zero_in_Mem,
    input  logic        Branch_in_Mem,
    input  logic        BranchN_in_Mem,
    input  logic        Jump_in_Mem,
    input  logic        MemRW_in_Mem,
    input  logic        RegWrite_in_Mem,
    input  logic [1:0]  MemtoReg_in_Mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out_Mem,
    output logic        PCSrc_out_Mem,
    output logic [31:0] PC_target_out_Mem,
    output logic        err_out_Mem,
    output logic        valid_out_Mem,
    output logic        RegWrite_out_Mem,
    output logic [4:0]  Rd_addr_out_Mem,
    output logic [1:0]  MemtoReg_out_Mem,
    output logic [31:0] ALU_out_Mem,
    output logic [31:0] Mem_data_out_Mem,
    output logic [31:0] PC4_out_Mem,
    output logic [31:0] PC_imm_out_Mem,
    output logic [31:0] inst_out_Mem,
    output logic [31:0] pc_out_Mem
);

    localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    memwb_t        memwb_q, memwb_d;

    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op, misaligned, timeout;
    logic        req_int, stall_int, acked;
    logic [3:0]  strb_raw;
    logic [31:0] load_data;

    assign funct3     = inst_in_Mem[14:12];
    assign is_load    = valid_in_Mem & (MemtoReg_in_Mem == MTR_LOAD);
    assign is_store   = valid_in_Mem & MemRW_in_Mem;
    assign mem_op     = is_load | is_store;
    assign misaligned = mem_op & is_misaligned(funct3, ALU_in_Mem[1:0]);
    assign timeout    = (state_q == S_BUSY) & (cnt_q == TO_LAST);

    // The request is dropped in the timeout cycle, so an ack there is ignored
    assign req_int   = ((state_q == S_IDLE) & mem_op & ~misaligned)
                     | ((state_q == S_BUSY) & ~timeout);
    assign acked     = req_int & dmem_ack;
    assign stall_int = req_int & ~dmem_ack & ~timeout;

    load_store_align u_align (
        .funct3     (funct3),
        .addr_lo    (ALU_in_Mem[1:0]),
        .store_data (Rs2_in_Mem),
        .load_word  (dmem_rdata),
        .wstrb      (strb_raw),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    // Combinational outputs are forced low while reset is held
    assign dmem_req      = req_int & ~rst_Mem;
    assign dmem_we       = dmem_req & is_store;
    assign dmem_wstrb    = dmem_we ? strb_raw : 4'b0000;
    assign dmem_addr     = {ALU_in_Mem[31:2], 2'b00};
    assign stall_out_Mem = stall_int & ~rst_Mem;
    assign err_out_Mem   = ~rst_Mem & (((state_q == S_IDLE) & misaligned) | timeout);
    assign PCSrc_out_Mem = ~rst_Mem & valid_in_Mem &
                           ((Branch_in_Mem & zero_in_Mem) | (BranchN_in_Mem & ~zero_in_Mem) | Jump_in_Mem);
    assign PC_target_out_Mem = (inst_in_Mem[6:0] == OPC_JALR) ? {ALU_in_Mem[31:1], 1'b0} : PC_imm_in_Mem;

    // Next state of the bus FSM and its timeout counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_int & ~dmem_ack) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (timeout | dmem_ack) state_d = S_IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus FSM state and timeout counter
    always_ff @(posedge clk_Mem or posedge rst_Mem) begin
        if (rst_Mem) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB contents: bubble while stalled, faulted accesses retire as bubbles
    always_comb begin
        memwb_d = memwb_q;
        if (stall_int) begin
            memwb_d.valid     = 1'b0;
            memwb_d.reg_write = 1'b0;
        end else begin
            memwb_d.valid      = valid_in_Mem & ~misaligned & ~timeout;
            memwb_d.reg_write  = valid_in_Mem & ~misaligned & ~timeout & RegWrite_in_Mem;
            memwb_d.rd_addr    = Rd_addr_in_Mem;
            memwb_d.mem_to_reg = mtr_e'(MemtoReg_in_Mem);
            memwb_d.alu        = ALU_in_Mem;
            memwb_d.mem_data   = (is_load & acked) ? load_data : 32'd0;
            memwb_d.pc4        = PC4_in_Mem;
            memwb_d.pc_imm     = PC_imm_in_Mem;
            memwb_d.inst       = inst_in_Mem;
            memwb_d.pc         = pc_in_Mem;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk_Mem or posedge rst_Mem) begin
        if (rst_Mem) memwb_q <= '0;
        else         memwb_q <= memwb_d;
    end

    assign valid_out_Mem    = memwb_q.valid;
    assign RegWrite_out_Mem = memwb_q.reg_write;
    assign Rd_addr_out_Mem  = memwb_q.rd_addr;
    assign MemtoReg_out_Mem = memwb_q.mem_to_reg;
    assign ALU_out_Mem      = memwb_q.alu;
    assign Mem_data_out_Mem = memwb_q.mem_data;
    assign PC4_out_Mem      = memwb_q.pc4;
    assign PC_imm_out_Mem   = memwb_q.pc_imm;
    assign inst_out_Mem     = memwb_q.inst;
    assign pc_out_Mem       = memwb_q.pc;

endmodule
